// File: rtl/ctrlsoc_flashcache.sv
// ---------------------------------------------------------------------------
// ctrlsoc_flashcache
//   Direct-mapped, one-word-per-line read cache in front of a slow flash
//   reader. A CPU read is looked up one cycle after it is accepted. A hit
//   answers immediately. A miss fetches the word from flash, fills the line
//   and answers with the flash data.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   valid        : CPU read request, held until ready
//   ready        : one-cycle pulse, rdata valid
//   addr[23:0]   : CPU byte address (word aligned, addr[1:0] ignored)
//   rdata[31:0]  : read data to CPU, held between responses
//   flush        : invalidate every line in one cycle
//   flash_valid  : request to flash reader, held until flash_ready
//   flash_ready  : one-cycle pulse, flash_rdata valid
//   flash_addr   : address presented to flash reader
//   flash_rdata  : flash read data
//   hit_count    : saturating hit counter
//   miss_count   : saturating miss counter
// ---------------------------------------------------------------------------
module ctrlsoc_flashcache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  input  logic        flush,
  output logic        flash_valid,
  input  logic        flash_ready,
  output logic [23:0] flash_addr,
  input  logic [31:0] flash_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 22 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request address latched when a lookup starts
  logic [23:0] r_addr;

  // Registered outputs
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_flash_valid;
  logic [23:0] r_flash_addr;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // Line state: valid bits in flops, tag/data in synchronous-read arrays
  logic [LINES-1:0] r_line_valid;
  logic [TAG_W-1:0] r_tag_mem  [LINES];
  logic [31:0]      r_data_mem [LINES];
  logic [TAG_W-1:0] r_tag_rd;
  logic [31:0]      r_data_rd;

  // A flush seen while a miss is outstanding: the fill still answers the
  // CPU but must not validate its line.
  logic r_flush_pend;

  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_lat_idx;
  logic [TAG_W-1:0] w_lat_tag;
  logic             w_lookup_hit;
  logic             w_latch;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill_done;
  logic             w_fill_we;
  logic             w_set_line;
  logic [LINES-1:0] w_line_set;
  logic             w_ready_next;
  logic [31:0]      w_rdata_next;
  logic             w_flash_valid_next;
  logic [23:0]      w_flash_addr_next;

  assign w_req_idx = addr[2 +: IDX_W];
  assign w_lat_idx = r_addr[2 +: IDX_W];
  assign w_lat_tag = r_addr[23:2+IDX_W];

  // A flush in the lookup cycle wins over a hit on the old contents
  assign w_lookup_hit = r_line_valid[w_lat_idx] && (r_tag_rd == w_lat_tag) && !flush;

  // ---------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_latch            = 1'b0;
    w_hit              = 1'b0;
    w_miss             = 1'b0;
    w_fill_done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // ready high means the held request was just answered
        if (valid && !r_ready) begin
          w_latch      = 1'b1;
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (w_lookup_hit) begin
          w_hit        = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_miss       = 1'b1;
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flash_ready) begin
          w_fill_done  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_ready_next       = w_hit || w_fill_done;
    w_rdata_next       = r_rdata;
    w_flash_valid_next = r_flash_valid;
    w_flash_addr_next  = r_flash_addr;
    if (w_hit) begin
      w_rdata_next = r_data_rd;
    end else if (w_fill_done) begin
      w_rdata_next = flash_rdata;
    end
    if (w_miss) begin
      w_flash_valid_next = 1'b1;
      w_flash_addr_next  = r_addr;
    end else if (w_fill_done) begin
      w_flash_valid_next = 1'b0;
    end
  end

  assign w_fill_we  = w_fill_done && !reset;
  assign w_set_line = w_fill_done && !flush && !r_flush_pend;

  // One-hot set mask for the line being filled
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line_set
    assign w_line_set[gi] = w_set_line && (w_lat_idx == IDX_W'(gi));
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath and statistics
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= 24'h0;
      r_ready       <= 1'b0;
      r_rdata       <= 32'h0;
      r_flash_valid <= 1'b0;
      r_flash_addr  <= 24'h0;
      r_hit_count   <= 16'h0;
      r_miss_count  <= 16'h0;
      r_flush_pend  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr <= addr;
      end
      r_ready       <= w_ready_next;
      r_rdata       <= w_rdata_next;
      r_flash_valid <= w_flash_valid_next;
      r_flash_addr  <= w_flash_addr_next;
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
      if (w_fill_done || (r_state == ST_IDLE)) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_line_valid <= '0;
    end else begin
      r_line_valid <= r_line_valid | w_line_set;
    end
  end

  // Tag/data arrays: no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag_mem[w_lat_idx]  <= w_lat_tag;
      r_data_mem[w_lat_idx] <= flash_rdata;
    end
    if (w_latch) begin
      r_tag_rd  <= r_tag_mem[w_req_idx];
      r_data_rd <= r_data_mem[w_req_idx];
    end
  end

  assign ready       = r_ready;
  assign rdata       = r_rdata;
  assign flash_valid = r_flash_valid;
  assign flash_addr  = r_flash_addr;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_ctrlsoc_flashcache.sv
// ---------------------------------------------------------------------------
// tb_ctrlsoc_flashcache
//   Self-checking bench for ctrlsoc_flashcache. The reference model is a
//   per-index record of which word address is currently cached, plus a flash
//   content table; hits, data and counters are predicted from that.
// ---------------------------------------------------------------------------
module tb_ctrlsoc_flashcache;

  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [23:0] addr;
  logic [31:0] rdata;
  logic        flush;
  logic        flash_valid;
  logic        flash_ready;
  logic [23:0] flash_addr;
  logic [31:0] flash_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  ctrlsoc_flashcache #(.LINES(LINES)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .ready       (ready),
    .addr        (addr),
    .rdata       (rdata),
    .flush       (flush),
    .flash_valid (flash_valid),
    .flash_ready (flash_ready),
    .flash_addr  (flash_addr),
    .flash_rdata (flash_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  bit          m_cached [LINES];
  logic [23:0] m_addr   [LINES];
  logic [31:0] flash_mem [bit [23:0]];
  int          m_hits;
  int          m_misses;
  logic [31:0] last_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [31:0] get_mem(input logic [23:0] a);
    if (!flash_mem.exists(a)) flash_mem[a] = $urandom;
    return flash_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_cached[i] = 1'b0;
  endtask

  // One CPU read. lat: flash latency in cycles after flash_valid is seen;
  // flush_at/reset_at: fill cycle on which to pulse flush/reset (0 = never);
  // hold: keep valid asserted through the ready cycle.
  task automatic do_read(input logic [23:0] a, input int lat, input int flush_at,
                         input int reset_at, input bit hold);
    int          idx;
    bit          exp_hit;
    logic [31:0] exp_data;
    bit          saw_fv = 0;
    bit          got_resp = 0;
    bit          was_reset = 0;
    bit          flushed = 0;
    int          cyc = 0;
    int          fill_cyc = 0;
    int          resp_cyc = 0;
    idx      = int'(a >> 2) % LINES;
    exp_hit  = m_cached[idx] && (m_addr[idx] == a);
    exp_data = get_mem(a);
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    while (!got_resp && !was_reset && cyc < lat + 20) begin
      @(negedge clk);
      cyc++;
      flash_ready = 1'b0;
      flush       = 1'b0;
      if (ready) begin
        got_resp = 1;
        resp_cyc = cyc;
      end else if (flash_valid) begin
        if (!saw_fv) check_val("flash_addr", flash_addr, a);
        saw_fv = 1;
        fill_cyc++;
        if (fill_cyc == reset_at) begin
          reset     = 1'b1;
          was_reset = 1;
        end else begin
          if (fill_cyc == flush_at) begin
            flush   = 1'b1;
            flushed = 1;
            model_clear();
          end
          if (fill_cyc == lat) begin
            check_val("flash_addr_held", flash_addr, a);
            flash_ready = 1'b1;
            flash_rdata = exp_data;
          end
        end
      end
    end

    if (was_reset) begin
      @(negedge clk);
      check_val("rst_flash_valid", flash_valid, 0);
      check_val("rst_ready", ready, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_counts", {hit_count, miss_count}, 0);
      reset = 1'b0;
      valid = 1'b0;
      model_clear();
      m_hits     = 0;
      m_misses   = 0;
      last_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check_val("rst_no_ready", {ready, flash_valid}, 0);
      $display("read a=%h reset in fill cycle %0d", a, reset_at);
      return;
    end

    if (!got_resp) begin
      check_val("timeout", 0, 1);
      valid       = 1'b0;
      flash_ready = 1'b0;
      flush       = 1'b0;
      return;
    end

    check_val("hit_path", !saw_fv, exp_hit);
    if (exp_hit) check_val("hit_latency", resp_cyc, 2);
    check_val("rdata", rdata, exp_data);
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      if (!flushed) begin
        m_cached[idx] = 1'b1;
        m_addr[idx]   = a;
      end
    end
    last_rdata = exp_data;

    if (!hold) valid = 1'b0;
    @(negedge clk);
    check_val("ready_pulse", ready, 0);
    valid = 1'b0;
    @(negedge clk);
    check_val("no_relaunch", {ready, flash_valid}, 0);
    check_val("rdata_hold", rdata, last_rdata);
    check_val("hit_count", hit_count, sat16(m_hits));
    check_val("miss_count", miss_count, sat16(m_misses));
    $display("read a=%h %s lat=%0d flush_at=%0d hold=%0d rdata=%h hits=%0d misses=%0d",
             a, exp_hit ? "hit" : "miss", lat, flush_at, hold, rdata, hit_count, miss_count);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    $display("flush");
  endtask

  // flash_ready while idle must be ignored
  task automatic stray_flash_ready();
    @(negedge clk);
    flash_ready = 1'b1;
    flash_rdata = $urandom;
    @(negedge clk);
    flash_ready = 1'b0;
    check_val("stray_ready", {ready, flash_valid}, 0);
    check_val("stray_rdata", rdata, last_rdata);
    $display("stray flash_ready ignored");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    int          lat;
    int          fl;
    reset       = 1'b1;
    valid       = 1'b0;
    addr        = 24'h0;
    flush       = 1'b0;
    flash_ready = 1'b0;
    flash_rdata = 32'h0;
    m_hits      = 0;
    m_misses    = 0;
    last_rdata  = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("reset_ready", ready, 0);
    check_val("reset_flash_valid", flash_valid, 0);
    check_val("reset_flash_addr", flash_addr, 0);
    check_val("reset_rdata", rdata, 0);
    check_val("reset_hit_count", hit_count, 0);
    check_val("reset_miss_count", miss_count, 0);
    reset = 1'b0;

    // Cold read with a long flash latency, then a hit on the same word
    flash_mem[24'h100000] = 32'hDEADBEEF;
    do_read(24'h100000, 34, 0, 0, 0);
    do_read(24'h100000, 34, 0, 0, 0);
    // Same index, different tag: conflict misses
    do_read(24'h100040, 4, 0, 0, 0);
    do_read(24'h100000, 4, 0, 0, 1);
    // Flush during a fill, then on the flash_ready cycle itself
    do_read(24'h100004, 6, 2, 0, 0);
    do_read(24'h100004, 3, 0, 0, 0);
    do_read(24'h10000C, 3, 3, 0, 0);
    do_read(24'h10000C, 3, 0, 0, 0);
    // Reset five cycles into a fill, then the same address misses
    do_read(24'h100008, 20, 0, 5, 0);
    do_read(24'h100008, 2, 0, 0, 0);
    stray_flash_ready();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) a = 24'($urandom) & 24'hFFFFFC;
      else a = 24'(32'h100000 + $urandom_range(0, 3) * 64 + $urandom_range(0, LINES - 1) * 4);
      lat = $urandom_range(1, 8);
      fl  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
      do_read(a, lat, fl, 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) do_flush();
      if ($urandom_range(0, 14) == 0) stray_flash_ready();
    end

    // Saturation of the hit counter
    do_read(24'h100000, 2, 0, 0, 0);
    @(negedge clk);
    force dut.r_hit_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_hit_count;
    m_hits = 65534;
    for (int n = 0; n < 3; n++) do_read(24'h100000, 2, 0, 0, 0);
    check_val("hit_saturate", hit_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
